// File: rtl/div_ctrl.sv
// div_ctrl: iterative radix-2 restoring divider with FSM sequencing for DIV/DIVU.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq
);
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] dividend, dividend_nxt, divisor, divisor_nxt, partial, partial_nxt;
  logic neg_q, neg_q_nxt, neg_r, neg_r_nxt, ready_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic [DATA_W:0] shifted, trial;
  logic [DATA_W-1:0] part_step, quo_step, abs1, abs2;
  assign stallreq = start & ~ready;
  // Quotient bits shift into the dividend register as the dividend shifts out.
  assign shifted   = {partial, dividend[DATA_W-1]};
  assign trial     = shifted - {1'b0, divisor};
  assign part_step = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_step  = {dividend[DATA_W-2:0], ~trial[DATA_W]};
  assign abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      partial  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      partial  <= partial_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result   <= result_nxt;
      ready    <= ready_nxt;
    end
  end
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    partial_nxt  = partial;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    result_nxt   = result;
    ready_nxt    = ready;
    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start && !annul) begin
          if (opdata2 == '0) state_nxt = BY_ZERO;
          else begin
            state_nxt    = ON;
            dividend_nxt = abs1;
            divisor_nxt  = abs2;
            partial_nxt  = '0;
            cnt_nxt      = '0;
            neg_q_nxt    = signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r_nxt    = signed_div & opdata1[DATA_W-1];
          end
        end
      end
      BY_ZERO: begin
        state_nxt  = annul ? FREE : END;
        result_nxt = '0;
        ready_nxt  = ~annul;
      end
      ON: begin
        if (annul) begin
          state_nxt  = FREE;
          cnt_nxt    = '0;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else begin
          partial_nxt  = part_step;
          dividend_nxt = quo_step;
          cnt_nxt      = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1)) begin
            state_nxt  = END;
            ready_nxt  = 1'b1;
            result_nxt = {neg_r ? -part_step : part_step, neg_q ? -quo_step : quo_step};
          end
        end
      end
      default: begin
        if (!start || annul) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for the iterative divider.
module tb_div_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
  logic [31:0] opdata1 = '0, opdata2 = '0;
  logic [63:0] result;
  logic ready, stallreq;
  int checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .stallreq(stallreq)
  );
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    if (push) exp_q.push_back(model(sgn, a, b));
  endtask
  // lat counts sampled cycles with ready low; st counts those with stallreq high.
  task automatic wait_ready(output int lat, output int st);
    lat = 0; st = 0;
    while (1) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (stallreq) st++;
      if (lat > 100) begin lat = -1; break; end
    end
  endtask
  task automatic release_start();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  function automatic logic [63:0] pop_exp();
    return (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL reset: ready=%b result=%h stallreq=%b want 0/0/0", ready, result, stallreq);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic test_divide();
    logic [31:0] ta[10] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'd7, 32'h8000_0000, -32'd100, 32'h8000_0000};
    logic [31:0] tb[10] = '{32'd7, 32'd1, 32'd9, 32'd5, 32'h0001_0000,
                            32'd2, -32'd2, 32'hFFFF_FFFF, -32'd7, 32'd3};
    logic ts[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0] exp;
    int lat, st;
    for (int i = 0; i < 10; i++) begin
      issue(ts[i], ta[i], tb[i], 1);
      wait_ready(lat, st);
      exp = pop_exp();
      checks++;
      if (lat !== 33 || st !== 33) begin
        errors++; $display("FAIL div%0d latency: lat=%0d stall=%0d want 33/33", i, lat, st);
      end
      checks++;
      if (result !== exp || stallreq !== 1'b0) begin
        errors++; $display("FAIL div%0d result: got %h stall=%b want %h stall=0", i, result, stallreq, exp);
      end
      release_start();
      checks++;
      if (ready !== 1'b0 || result !== 64'd0) begin
        errors++; $display("FAIL div%0d release: ready=%b result=%h want 0/0", i, ready, result);
      end
    end
  endtask
  task automatic test_div_zero();
    logic [63:0] exp;
    int lat, st;
    issue(1'b0, 32'h1234, 32'd0, 1);
    wait_ready(lat, st);
    exp = pop_exp();
    checks++;
    if (lat !== 2 || result !== exp) begin
      errors++; $display("FAIL div_zero: lat=%0d result=%h want 2 %h", lat, result, exp);
    end
    release_start();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL div_zero release: ready=%b want 0", ready);
    end
  endtask
  task automatic test_annul();
    logic [63:0] exp;
    int lat, st, bad;
    issue(1'b0, 32'd1000, 32'd3, 0);
    repeat (10) @(posedge clk);
    checks++;
    if (stallreq !== 1'b1) begin
      errors++; $display("FAIL annul pre: stallreq=%b want 1", stallreq);
    end
    #1 annul = 1'b1; start = 1'b0;
    @(posedge clk); #1 annul = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0 || stallreq !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL annul idle: bad_cycles=%0d want 0", bad);
    end
    issue(1'b0, 32'd1000, 32'd3, 1);
    wait_ready(lat, st);
    exp = pop_exp();
    checks++;
    if (lat !== 33 || result !== exp || result !== {32'd1, 32'd333}) begin
      errors++; $display("FAIL annul reissue: lat=%0d result=%h want 33 %h", lat, result, exp);
    end
    release_start();
  endtask
  task automatic test_hold_back_to_back();
    logic [63:0] exp;
    int lat, st, bad;
    issue(1'b1, -32'd100, 32'd7, 1);
    wait_ready(lat, st);
    exp = pop_exp();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b1 || result !== exp) bad++;
    end
    checks++;
    if (lat !== 33 || bad !== 0) begin
      errors++; $display("FAIL hold: lat=%0d unstable_cycles=%0d result=%h want 33 0 %h", lat, bad, result, exp);
    end
    release_start();
    issue(1'b0, 32'd77, 32'd5, 1);
    wait_ready(lat, st);
    exp = pop_exp();
    checks++;
    if (lat !== 33 || result !== exp) begin
      errors++; $display("FAIL back_to_back: lat=%0d result=%h want 33 %h", lat, result, exp);
    end
    release_start();
  endtask
  task automatic test_reset_mid();
    logic [63:0] exp;
    int lat, st;
    issue(1'b0, 32'd1000, 32'd3, 0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL reset_mid: ready=%b result=%h stallreq=%b want 0/0/0", ready, result, stallreq);
    end
    issue(1'b1, -32'd1000, 32'd3, 1);
    wait_ready(lat, st);
    exp = pop_exp();
    checks++;
    if (lat !== 33 || result !== exp) begin
      errors++; $display("FAIL reset_mid reissue: lat=%0d result=%h want 33 %h", lat, result, exp);
    end
    release_start();
  endtask
  task automatic test_operand_change();
    logic [63:0] exp;
    int lat, st;
    issue(1'b0, 32'd500, 32'd4, 1);
    @(posedge clk); #1 opdata1 = 32'd9; opdata2 = 32'd0; signed_div = 1'b1;
    wait_ready(lat, st);
    exp = pop_exp();
    checks++;
    if (lat !== 32 || result !== exp) begin
      errors++; $display("FAIL operand_change: lat=%0d result=%h want 32 %h", lat, result, exp);
    end
    release_start();
  endtask
  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_annul();
    test_hold_back_to_back();
    test_reset_mid();
    test_operand_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
